round_robin_arbiter: RTL and testbench

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

---
 rtl/round_robin_arbiter.sv | 151 +++++++++++++++
 tb/tb_round_robin_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with a per-grant hold limit.
// One requester holds the grant until it signals done, drops its request,
// or reaches MAX_HOLD cycles; a revocation by the hold limit alone raises
// a one-cycle timeout pulse. Every grant is followed by at least one idle
// cycle before the next arbitration.
module round_robin_arbiter #(
    parameter int  WIDTH    = 8,
    parameter int  MAX_HOLD = 16,
    localparam int ID_W     = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic [WIDTH-1:0] req_i,
    input  logic             done_i,
    output logic [WIDTH-1:0] grant_o,
    output logic [ID_W-1:0]  grant_id_o,
    output logic             grant_valid_o,
    output logic             timeout_o
);

    localparam int                HOLD_W   = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t            state_r,   state_s;
    logic [WIDTH-1:0]  grant_r,   grant_s;
    logic [ID_W-1:0]   id_r,      id_s;
    logic [ID_W-1:0]   ptr_r,     ptr_s;
    logic [HOLD_W-1:0] hold_r,    hold_s;
    logic              valid_r,   valid_s;
    logic              timeout_r, timeout_s;

    logic [WIDTH-1:0]  hi_mask_s;
    logic [WIDTH-1:0]  hi_req_s;
    logic [ID_W-1:0]   hi_id_s;
    logic [ID_W-1:0]   lo_id_s;
    logic [ID_W-1:0]   win_id_s;
    logic              rel_done_s;
    logic              rel_limit_s;

    // One-hot decode of a requester index.
    function automatic logic [WIDTH-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [WIDTH-1:0] onehot;
        onehot     = '0;
        onehot[id] = 1'b1;
        return onehot;
    endfunction

    // Pointer value following a grant to index id, wrapping at WIDTH-1.
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
        if (int'(id) == WIDTH - 1) begin
            return '0;
        end else begin
            return id + ID_W'(1);
        end
    endfunction

    // Winner search: lowest requester at or above ptr, else lowest overall.
    always_comb begin
        hi_mask_s = '0;
        hi_req_s  = '0;
        hi_id_s   = '0;
        lo_id_s   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hi_mask_s[i] = (i >= int'(ptr_r));
        end
        hi_req_s = req_i & hi_mask_s;
        // Scan downward so the last hit is the lowest set index.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            lo_id_s = req_i[i]    ? ID_W'(i) : lo_id_s;
            hi_id_s = hi_req_s[i] ? ID_W'(i) : hi_id_s;
        end
        win_id_s = (|hi_req_s) ? hi_id_s : lo_id_s;
    end

    // Next-state and next-output logic for the IDLE/GRANT machine.
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        id_s        = id_r;
        ptr_s       = ptr_r;
        hold_s      = hold_r;
        valid_s     = valid_r;
        timeout_s   = 1'b0;
        rel_done_s  = done_i | ~req_i[id_r];
        rel_limit_s = (hold_r == HOLD_MAX);
        case (state_r)
            ST_IDLE: begin
                if (|req_i) begin
                    state_s = ST_GRANT;
                    grant_s = id_to_onehot(win_id_s);
                    id_s    = win_id_s;
                    ptr_s   = next_ptr(win_id_s);
                    hold_s  = '0;
                    valid_s = 1'b1;
                end else begin
                    grant_s = '0;
                    valid_s = 1'b0;
                end
            end
            ST_GRANT: begin
                if (rel_done_s || rel_limit_s) begin
                    state_s   = ST_IDLE;
                    grant_s   = '0;
                    valid_s   = 1'b0;
                    // A done or a request drop takes precedence over the limit.
                    timeout_s = rel_limit_s & ~rel_done_s;
                end else begin
                    hold_s = (hold_r == HOLD_MAX) ? hold_r : hold_r + HOLD_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = '0;
                valid_s = 1'b0;
                hold_s  = '0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_r   <= ST_IDLE;
            grant_r   <= '0;
            id_r      <= '0;
            ptr_r     <= '0;
            hold_r    <= '0;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            grant_r   <= grant_s;
            id_r      <= id_s;
            ptr_r     <= ptr_s;
            hold_r    <= hold_s;
            valid_r   <= valid_s;
            timeout_r <= timeout_s;
        end
    end

    assign grant_o       = grant_r;
    assign grant_id_o    = id_r;
    assign grant_valid_o = valid_r;
    assign timeout_o     = timeout_r;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Testbench for round_robin_arbiter (WIDTH=4, MAX_HOLD=4): directed
// scenarios followed by randomized traffic, all checked against a
// cycle-level behavioural model of the arbitration rules.
module tb_round_robin_arbiter;

    localparam int WIDTH    = 4;
    localparam int MAX_HOLD = 4;
    localparam int ID_W     = 2;

    logic             clk_i = 1'b0;
    logic             arst_n_i;
    logic [WIDTH-1:0] req_i;
    logic             done_i;
    logic [WIDTH-1:0] grant_o;
    logic [ID_W-1:0]  grant_id_o;
    logic             grant_valid_o;
    logic             timeout_o;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: busy flag, holder, pointer, cycles held so far.
    int m_busy;
    int m_id;
    int m_ptr;
    int m_held;
    int m_to;

    round_robin_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk_i         (clk_i),
        .arst_n_i      (arst_n_i),
        .req_i         (req_i),
        .done_i        (done_i),
        .grant_o       (grant_o),
        .grant_id_o    (grant_id_o),
        .grant_valid_o (grant_valid_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_id   = 0;
        m_ptr  = 0;
        m_held = 0;
        m_to   = 0;
    endtask

    // One rising edge of the reference: rotate-search from the pointer in
    // idle; otherwise count held cycles and decide the release cause.
    task automatic model_edge(input logic [WIDTH-1:0] req, input logic done);
        int found;
        int rd;
        int rl;
        m_to = 0;
        if (m_busy == 0) begin
            found = 0;
            for (int off = 0; off < WIDTH; off++) begin
                int k;
                k = (m_ptr + off) % WIDTH;
                if (found == 0 && req[k] == 1'b1) begin
                    found  = 1;
                    m_busy = 1;
                    m_id   = k;
                    m_ptr  = (k + 1) % WIDTH;
                    m_held = 1;
                end
            end
        end else begin
            rd = (done == 1'b1 || req[m_id] == 1'b0) ? 1 : 0;
            rl = (m_held >= MAX_HOLD) ? 1 : 0;
            if (rd != 0 || rl != 0) begin
                m_busy = 0;
                m_to   = (rl != 0 && rd == 0) ? 1 : 0;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] exp_grant;
        exp_grant = (m_busy != 0) ? (32'd1 << m_id) : 32'd0;
        chk({tag, ".grant"},   32'(grant_o),       exp_grant);
        chk({tag, ".id"},      32'(grant_id_o),    32'(m_id));
        chk({tag, ".valid"},   32'(grant_valid_o), 32'(m_busy));
        chk({tag, ".timeout"}, 32'(timeout_o),     32'(m_to));
    endtask

    // Apply inputs, take one rising edge, advance the model, check after the edge.
    task automatic step(input logic [WIDTH-1:0] req, input logic done, input string tag);
        req_i  = req;
        done_i = done;
        @(posedge clk_i);
        model_edge(req, done);
        #1;
        vectors++;
        check_model(tag);
    endtask

    // Reset asserted between clock edges; outputs must clear without an edge.
    task automatic async_reset(input string tag);
        arst_n_i = 1'b0;
        #1;
        model_reset();
        vectors++;
        check_model(tag);
        chk({tag, ".zero"}, 32'({grant_o, grant_id_o, grant_valid_o, timeout_o}), 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        arst_n_i = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] r_req;
        logic             r_done;

        arst_n_i = 1'b0;
        req_i    = 4'b0000;
        done_i   = 1'b0;
        model_reset();
        #2;
        vectors++;
        check_model("reset");
        chk("reset.zero", 32'({grant_o, grant_id_o, grant_valid_o, timeout_o}), 32'd0);
        @(negedge clk_i);
        arst_n_i = 1'b1;

        // Single requester, done on the third grant cycle.
        step(4'b0100, 1'b0, "single.g1");
        chk("single.grant", 32'(grant_o), 32'h4);
        chk("single.id", 32'(grant_id_o), 32'd2);
        step(4'b0100, 1'b0, "single.g2");
        step(4'b0100, 1'b0, "single.g3");
        step(4'b0100, 1'b1, "single.rel");
        chk("single.released", 32'(grant_o), 32'd0);
        chk("single.no_to", 32'(timeout_o), 32'd0);
        chk("single.id_hold", 32'(grant_id_o), 32'd2);
        step(4'b0000, 1'b1, "idle.done_ignored");

        // Pointer is 3: requests 0 and 1 wrap to index 0, then 1.
        step(4'b0011, 1'b0, "wrap.g0");
        chk("wrap.id0", 32'(grant_id_o), 32'd0);
        step(4'b0011, 1'b1, "wrap.rel0");
        step(4'b0011, 1'b0, "wrap.g1");
        chk("wrap.id1", 32'(grant_id_o), 32'd1);
        step(4'b0011, 1'b1, "wrap.rel1");

        // Rotation from a fresh pointer.
        async_reset("rot.reset");
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b0, "rot.grant");
            chk("rot.order", 32'(grant_id_o), 32'(i % WIDTH));
            step(4'b1111, 1'b1, "rot.rel");
            chk("rot.gap", 32'(grant_o), 32'd0);
        end

        // Hold limit reached with the request still up.
        step(4'b0010, 1'b0, "to.g1");
        step(4'b0010, 1'b0, "to.g2");
        step(4'b0010, 1'b0, "to.g3");
        step(4'b0010, 1'b0, "to.g4");
        chk("to.still_granted", 32'(grant_o), 32'h2);
        step(4'b0010, 1'b0, "to.revoke");
        chk("to.pulse", 32'(timeout_o), 32'd1);
        chk("to.cleared", 32'(grant_o), 32'd0);
        step(4'b0010, 1'b0, "to.regrant");
        chk("to.pulse_end", 32'(timeout_o), 32'd0);
        chk("to.regrant_grant", 32'(grant_o), 32'h2);
        step(4'b0000, 1'b0, "to.drop");
        step(4'b0000, 1'b0, "to.idle");

        // done in the same cycle as the hold limit: no timeout.
        step(4'b0001, 1'b0, "sim.g1");
        step(4'b0001, 1'b0, "sim.g2");
        step(4'b0001, 1'b0, "sim.g3");
        step(4'b0001, 1'b0, "sim.g4");
        step(4'b0001, 1'b1, "sim.rel");
        chk("sim.no_to", 32'(timeout_o), 32'd0);
        chk("sim.released", 32'(grant_o), 32'd0);

        // Other bits toggling are ignored; dropping the holder's bit releases.
        step(4'b0100, 1'b0, "drop.g");
        step(4'b1111, 1'b0, "drop.others");
        chk("drop.others_ignored", 32'(grant_o), 32'h4);
        step(4'b1011, 1'b0, "drop.rel");
        chk("drop.released", 32'(grant_o), 32'd0);
        step(4'b0000, 1'b0, "drop.idle");

        // Reset in the middle of a grant to index 3.
        step(4'b1000, 1'b0, "rstmid.g");
        chk("rstmid.grant", 32'(grant_o), 32'h8);
        async_reset("rstmid");
        step(4'b1001, 1'b0, "rstmid.first");
        chk("rstmid.first_id", 32'(grant_id_o), 32'd0);
        step(4'b0000, 1'b0, "rstmid.idle");

        // Randomized traffic with sticky requests so the limit gets hit.
        r_req = 4'b0000;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                r_req = 4'($urandom_range(0, 15));
            end
            r_done = ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rand.reset");
            end
            step(r_req, r_done, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
